// File: rtl/lr_train_sequencer.sv
// Handshaked epoch/datapoint sequencer for the linear-regression training datapath.
// Optional early-stop criterion enabled by defining LR_SEQ_EARLY_STOP_EN.
module lr_train_sequencer #(
    parameter int DP_BITS    = 4,
    parameter int EPOCH_BITS = 6,
    parameter int RAM_LAT    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DP_BITS-1:0]    num_dps,
    input  logic [EPOCH_BITS-1:0] num_epochs,
    output logic                  ram_oe,
    output logic [DP_BITS-1:0]    ram_addr,
    output logic                  load_x,
    output logic                  calc_go,
    input  logic                  calc_done,
    input  logic                  err_small,
    output logic                  upd_go,
    input  logic                  upd_done,
    output logic                  busy,
    output logic                  fin,
    output logic [EPOCH_BITS-1:0] epoch_cnt,
    output logic                  stopped_early
);

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, CALC_REQ, CALC_WAIT, UPD_REQ, UPD_WAIT, NEXT, DONE
    } state_t;

    localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [DP_BITS-1:0]    DP_ONE    = DP_BITS'(1);
    localparam logic [EPOCH_BITS-1:0] EPOCH_ONE = EPOCH_BITS'(1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(RAM_LAT - 1);

    state_t                state, state_d;
    logic [DP_BITS-1:0]    addr_d, dps_q, dps_d;
    logic [EPOCH_BITS-1:0] epochs_q, epochs_d, cnt_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  es_flag, es_flag_d, stop_q, stop_d;

    // Everything visible outside is a decode of the registered state.
    assign ram_oe   = (state == FETCH) || (state == LOAD);
    assign load_x   = (state == LOAD);
    assign calc_go  = (state == CALC_REQ);
    assign upd_go   = (state == UPD_REQ);
    assign busy     = (state != IDLE) && (state != DONE);
    assign fin      = (state == DONE);

`ifdef LR_SEQ_EARLY_STOP_EN
    assign stopped_early = stop_q;
`else
    logic unused_err_small;
    assign unused_err_small = err_small;
    assign stopped_early    = 1'b0;
`endif

    // NOTE: every next-value is given its hold value before the case so no path infers a latch.
    always_comb begin
        state_d   = state;
        addr_d    = ram_addr;
        dps_d     = dps_q;
        epochs_d  = epochs_q;
        cnt_d     = epoch_cnt;
        wait_d    = wait_q;
        es_flag_d = es_flag;
        stop_d    = stop_q;
        if (abort) begin
            state_d = IDLE;
            addr_d  = '0;
            wait_d  = '0;
            stop_d  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    dps_d    = num_dps;
                    epochs_d = num_epochs;
                    cnt_d    = '0;
                    stop_d   = 1'b0;
                    wait_d   = '0;
                    addr_d   = num_dps - DP_ONE;
                    state_d  = (num_dps == '0 || num_epochs == '0) ? DONE : FETCH;
                end
                FETCH: begin
`ifdef LR_SEQ_EARLY_STOP_EN
                    if (ram_addr == dps_q - DP_ONE) es_flag_d = 1'b1;
`endif
                    if (wait_q == WAIT_LAST) begin
                        wait_d  = '0;
                        state_d = LOAD;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                LOAD:      state_d = CALC_REQ;
                CALC_REQ:  state_d = CALC_WAIT;
                CALC_WAIT: if (calc_done) begin
`ifdef LR_SEQ_EARLY_STOP_EN
                    es_flag_d = es_flag & err_small;
`endif
                    state_d = UPD_REQ;
                end
                UPD_REQ:   state_d = UPD_WAIT;
                UPD_WAIT:  if (upd_done) state_d = NEXT;
                NEXT: begin
                    if (ram_addr != '0) begin
                        addr_d  = ram_addr - DP_ONE;
                        state_d = FETCH;
                    end else begin
                        cnt_d  = epoch_cnt + EPOCH_ONE;
                        addr_d = dps_q - DP_ONE;
`ifdef LR_SEQ_EARLY_STOP_EN
                        if (es_flag) begin
                            stop_d  = 1'b1;
                            state_d = DONE;
                        end else
`endif
                        state_d = (cnt_d == epochs_q) ? DONE : FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: registers update with non-blocking assignments so all see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ram_addr  <= '0;
            dps_q     <= '0;
            epochs_q  <= '0;
            epoch_cnt <= '0;
            wait_q    <= '0;
            es_flag   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state     <= state_d;
            ram_addr  <= addr_d;
            dps_q     <= dps_d;
            epochs_q  <= epochs_d;
            epoch_cnt <= cnt_d;
            wait_q    <= wait_d;
            es_flag   <= es_flag_d;
            stop_q    <= stop_d;
        end
    end

endmodule

// File: tb/tb_lr_train_sequencer.sv
// Directed bench for lr_train_sequencer with a small datapath responder.
module tb_lr_train_sequencer;

    logic       clk, rst, start, abort, calc_done, err_small, upd_done;
    logic [3:0] num_dps, ram_addr;
    logic [5:0] num_epochs, epoch_cnt;
    logic       ram_oe, load_x, calc_go, upd_go, busy, fin, stopped_early;

    lr_train_sequencer dut (
        .CLK(clk), .RST(rst), .start(start), .abort(abort),
        .num_dps(num_dps), .num_epochs(num_epochs),
        .ram_oe(ram_oe), .ram_addr(ram_addr), .load_x(load_x),
        .calc_go(calc_go), .calc_done(calc_done), .err_small(err_small),
        .upd_go(upd_go), .upd_done(upd_done), .busy(busy), .fin(fin),
        .epoch_cnt(epoch_cnt), .stopped_early(stopped_early)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] addr_log[$];
    int  cyc = 0, upd_cnt = 0, calc_go_cyc = 0, upd_go_cyc = 0;
    int  calc_dly = 1, upd_dly = 1, calc_rem = 0, upd_rem = 0, stray_rem = 0;
    bit  calc_pend = 0, upd_pend = 0, stray_en = 0, oe_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: answers each go after a programmable delay and logs activity.
    initial begin
        calc_done = 1'b0;
        upd_done  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (load_x) addr_log.push_back(ram_addr);
            if (ram_oe) oe_seen = 1;
            if (upd_go) begin upd_cnt++; upd_go_cyc = cyc; end
            calc_done = 1'b0;
            upd_done  = 1'b0;
            if (calc_pend) begin
                calc_rem--;
                if (calc_rem == 0) begin calc_done = 1'b1; calc_pend = 0; end
            end
            if (upd_pend) begin
                upd_rem--;
                if (upd_rem == 0) begin upd_done = 1'b1; upd_pend = 0; end
            end
            if (stray_rem > 0) begin
                stray_rem--;
                if (stray_rem == 0) upd_done = 1'b1;
            end
            if (calc_go) begin
                calc_pend = 1; calc_rem = calc_dly; calc_go_cyc = cyc;
                if (stray_en) stray_rem = 2;
            end
            if (upd_go) begin upd_pend = 1; upd_rem = upd_dly; end
        end
    end

    task automatic launch(input int dps, input int ep);
        @(negedge clk);
        num_dps = 4'(dps);
        num_epochs = 6'(ep);
        start = 1'b1;
        addr_log.delete();
        upd_cnt = 0;
        oe_seen = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle (start-accept edge = 0) at which fin is first seen.
    task automatic wait_fin(output int n);
        n = 1;
        while (!fin && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_log(input string tag, input int exp_len, input logic [3:0] first);
        check({tag, "_len"}, addr_log.size(), exp_len);
        for (int i = 0; i < exp_len && i < addr_log.size(); i++)
            check({tag, "_addr"}, addr_log[i], (first - 4'(i % (first + 1))));
    endtask

    int  n;
    bit  found;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; err_small = 1'b0;
        num_dps = '0; num_epochs = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {ram_oe, load_x, calc_go, upd_go, busy, fin, stopped_early}, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_epoch", epoch_cnt, 0);
        rst = 1'b0;

        // Zero epochs / zero points: straight to DONE without touching RAM.
        launch(3, 0);
        wait_fin(n);
        check("ep0_fin_cycle", n, 1);
        check("ep0_no_oe", oe_seen, 0);
        check("ep0_addr", ram_addr, 2);
        launch(0, 5);
        wait_fin(n);
        check("dp0_fin_cycle", n, 1);
        check("dp0_no_oe", oe_seen, 0);
        check("dp0_busy", busy, 0);

        // Nominal run: 3 points x 2 epochs at 7 cycles per point.
        launch(3, 2);
        wait_fin(n);
        check("nom_fin_cycle", n, 43);
        check_log("nom", 6, 4'd2);
        check("nom_upd_cnt", upd_cnt, 6);
        check("nom_epoch", epoch_cnt, 2);
        check("nom_addr_hold", ram_addr, 2);
        repeat (3) @(negedge clk);
        check("nom_fin_held", fin, 1);
        check("nom_busy", busy, 0);

        // Slow calc with a stray upd_done inside CALC_WAIT.
        calc_dly = 5;
        stray_en = 1;
        launch(1, 1);
        wait_fin(n);
        check("slow_fin_cycle", n, 12);
        check("slow_upd_cnt", upd_cnt, 1);
        check("slow_go_gap", upd_go_cyc - calc_go_cyc, 6);
        stray_en = 0;
        calc_dly = 1;
        repeat (4) @(negedge clk);

        // Abort in UPD_WAIT of epoch 1, address 1, then restart.
        upd_dly = 4;
        launch(3, 2);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (upd_go && ram_addr == 4'd1 && epoch_cnt == 6'd1) found = 1;
        end
        check("abort_reached", found, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_fin", fin, 0);
        check("abort_addr", ram_addr, 0);
        check("abort_epoch", epoch_cnt, 1);
        repeat (8) @(negedge clk);
        check("abort_idle_fin", fin, 0);
        upd_dly = 1;
        launch(3, 1);
        check("restart_busy", busy, 1);
        check("restart_addr", ram_addr, 2);
        check("restart_epoch", epoch_cnt, 0);
        wait_fin(n);
        check("restart_fin_cycle", n, 22);
        check_log("restart", 3, 4'd2);
        check("restart_epoch_end", epoch_cnt, 1);

        // start pulses while busy must not disturb the run.
        launch(3, 1);
        repeat (6) begin
            @(negedge clk);
            start = 1'b1; num_dps = 4'd7; num_epochs = 6'd9;
        end
        @(negedge clk);
        start = 1'b0;
        wait_fin(n);
        check("busy_start_fin", fin, 1);
        check_log("busy_start", 3, 4'd2);
        check("busy_start_epoch", epoch_cnt, 1);

        // Reset in the middle of CALC_WAIT.
        calc_dly = 6;
        launch(1, 3);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (calc_go && epoch_cnt == 6'd1) found = 1;
        end
        check("rst_mid_reached", found, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ctrl", {ram_oe, load_x, calc_go, upd_go, busy, fin, stopped_early}, 0);
        check("rst_mid_addr", ram_addr, 0);
        check("rst_mid_epoch", epoch_cnt, 0);
        calc_dly = 1;
        repeat (10) @(negedge clk);

        // Early-stop criterion: err_small held high for a 10-epoch run.
        err_small = 1'b1;
        launch(2, 10);
        wait_fin(n);
`ifdef LR_SEQ_EARLY_STOP_EN
        check("es_fin_cycle", n, 15);
        check("es_epoch", epoch_cnt, 1);
        check("es_stopped", stopped_early, 1);
`else
        check("es_fin_cycle", n, 141);
        check("es_epoch", epoch_cnt, 10);
        check("es_stopped", stopped_early, 0);
`endif
        err_small = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lr_train_sequencer.md
# lr_train_sequencer

Control FSM that sequences one linear-regression training run over the datapoint RAM and the shared multiplier/update datapath. On `start` it walks every datapoint, in descending address order, for a programmed number of epochs. For each point it issues the RAM read, feature load, prediction/error phase and weight-update phase, each with a req/done handshake. It replaces free-running per-phase stepping with a handshaked, restartable and abortable schedule, and reports `busy`/`fin` to the top level.

## Interface
Parameters:
- `DP_BITS`, 4, width of datapoint index and count (max 2^DP_BITS−1 points)
- `EPOCH_BITS`, 6, width of epoch count
- `RAM_LAT`, 1, RAM read latency in cycles, ≥1

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `start`  in  1  launch run; sampled only in IDLE or DONE
- `abort`  in  1  synchronous abandon; returns to IDLE, no `fin`
- `num_dps`  in  DP_BITS  datapoints per epoch, latched on accepted `start`
- `num_epochs`  in  EPOCH_BITS  epochs to run, latched on accepted `start`
- `ram_oe`  out  1  RAM output enable
- `ram_addr`  out  DP_BITS  RAM address (current datapoint)
- `load_x`  out  1  1-cycle pulse: datapath captures features and y from RAM data
- `calc_go`  out  1  1-cycle pulse: start prediction/error phase
- `calc_done`  in  1  datapath finished prediction; error term valid
- `err_small`  in  1  |y−ŷ| under threshold; qualified by `calc_done`
- `upd_go`  out  1  1-cycle pulse: start weight update
- `upd_done`  in  1  weights committed
- `busy`  out  1  high in every state except IDLE and DONE
- `fin`  out  1  run complete; held until next accepted `start` or `RST`
- `epoch_cnt`  out  EPOCH_BITS  completed epochs
- `stopped_early`  out  1  run ended by early-stop criterion

## Operation
- States: IDLE, FETCH, LOAD, CALC_REQ, CALC_WAIT, UPD_REQ, UPD_WAIT, NEXT, DONE.
- IDLE/DONE + `start`: latch `num_dps` and `num_epochs`, clear `epoch_cnt`, `stopped_early` and `fin`, then set `ram_addr = num_dps−1`.
  - If either latched value is 0, go to DONE with no RAM access.
  - Otherwise go to FETCH.
- FETCH: `ram_oe=1` for RAM_LAT cycles (internal wait counter), then go to LOAD.
- LOAD: `ram_oe=1` and `load_x=1` for one cycle, then go to CALC_REQ.
- CALC_REQ: `calc_go=1` for one cycle, then go to CALC_WAIT. `calc_done` is ignored in this state.
- CALC_WAIT: hold until `calc_done`, then go to UPD_REQ.
- UPD_REQ and UPD_WAIT behave identically to the calc pair, using `upd_go`/`upd_done`.
- NEXT:
  - If `ram_addr != 0`: decrement `ram_addr` and go to FETCH.
  - Otherwise: increment `epoch_cnt` and reload `ram_addr = num_dps−1`. If `epoch_cnt+1 == num_epochs`, go to DONE; otherwise go to FETCH.
- DONE: `fin=1`. `ram_addr` holds its last value.
- `start` while `busy` is ignored.
- `abort` in any state goes to IDLE next cycle. It clears all outputs except `epoch_cnt`, and `fin` stays 0. `abort` has priority over `start` and over all handshakes.
- `RST` has priority over everything. Reset values: state IDLE, all outputs 0.
- Counter arithmetic is unsigned modulo width. `epoch_cnt` never exceeds `num_epochs`.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational input-to-output path.
- Per datapoint minimum is RAM_LAT+6 cycles (7 at default), reached when each done arrives the cycle after its go.
- RAM data is valid in the LOAD cycle, RAM_LAT cycles after `ram_addr` changes.
- `fin` rises in the cycle after the NEXT state that completes the final epoch.
- Datapath handshakes are single-outstanding: exactly one `calc_go` per `calc_done` and one `upd_go` per `upd_done`. Dones arriving outside a WAIT state are dropped.

## Configuration
- `LR_SEQ_EARLY_STOP_EN` defined:
  - A per-epoch flag sets in FETCH at address `num_dps−1`.
  - The flag ANDs with `err_small` on each `calc_done` in CALC_WAIT.
  - In NEXT at address 0, if the flag is still 1 the run goes to DONE with `stopped_early=1`. `epoch_cnt` is still incremented.
- Undefined: `err_small` is ignored, `stopped_early` is tied 0, and exactly `num_epochs` epochs always run.

## Test plan
- `num_dps=3`, `num_epochs=2`, dones 1 cycle after each go → addresses 2,1,0,2,1,0; six `upd_go` pulses; `fin` at cycle 43 after `start` (6×7 + 1); `epoch_cnt=2`.
- `calc_done` delayed 5 cycles, `upd_done` pulsed during CALC_WAIT → stray `upd_done` ignored; `upd_go` issued only after `calc_done`.
- `num_epochs=0` → `fin` one cycle after `start`; `ram_oe` never asserted.
- `abort` during UPD_WAIT of epoch 1, addr 1 → IDLE next cycle, `fin=0`, `busy=0`; a new `start` restarts at addr `num_dps−1` with `epoch_cnt=0`.
- `RST` pulsed mid-CALC_WAIT, `start` asserted while busy → all outputs 0 after reset; busy-time `start` has no effect on addresses.
- Macro defined, `err_small=1` throughout, `num_epochs=10` → DONE after epoch 1 with `stopped_early=1`, `epoch_cnt=1`. Same stimulus with macro undefined → `epoch_cnt=10`.
